addition_subtraction: RTL and testbench



---
 rtl/addition_subtraction.sv | 164 ++++++++++++++++
 tb/tb_addition_subtraction.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/addition_subtraction.sv
// Single-precision IEEE-754 add/subtract with one registered output stage.
// Define ROUND_NEAREST_EN for round-to-nearest-even; default build truncates (round toward zero).
module addition_subtraction #(
    parameter int unsigned EXP_BITS  = 8,
    parameter int unsigned FRAC_BITS = 23
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          in_valid,
    input  logic [EXP_BITS+FRAC_BITS:0]   a_operand,
    input  logic [EXP_BITS+FRAC_BITS:0]   b_operand,
    input  logic                          AddBar_Sub,
    output logic                          out_valid,
    output logic                          Exception,
    output logic [EXP_BITS+FRAC_BITS:0]   result
);

    localparam int unsigned W     = EXP_BITS + FRAC_BITS + 1;
    localparam int unsigned SIG_W = FRAC_BITS + 1;
    localparam int unsigned EXT_W = SIG_W + 3;
    localparam int unsigned XW    = EXP_BITS + 2;
    localparam int unsigned LZC_W = $clog2(EXT_W + 1);

    localparam logic [EXP_BITS-1:0] EXP_MAX   = '1;
    localparam logic [EXP_BITS-1:0] SHIFT_LIM = EXP_BITS'(EXT_W - 1);
    localparam logic [W-1:0]        QNAN      = {1'b0, EXP_MAX, 1'b1, (FRAC_BITS-1)'(0)};

    // Leading-zero count; the highest set bit wins because the loop walks upward.
    function automatic logic [LZC_W-1:0] lzc(input logic [EXT_W-1:0] v);
        lzc = LZC_W'(EXT_W);
        for (int i = 0; i < EXT_W; i++) begin
            if (v[i]) lzc = LZC_W'(EXT_W - 1 - i);
        end
    endfunction

    logic                 a_sign, b_sign, l_sign, s_sign;
    logic [EXP_BITS-1:0]  a_exp, b_exp, l_exp, s_exp, exp_diff;
    logic [FRAC_BITS-1:0] a_frac, b_frac, l_frac, s_frac, frac_r;
    logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic                 swap, eff_sub, mag_zero, round_up;
    logic [EXT_W-1:0]     ext_l, ext_s, aligned, dif, norm;
    logic [EXT_W:0]       sum;
    logic [LZC_W-1:0]     lz;
    logic [XW-1:0]        exp_n, exp_r;
    logic [SIG_W:0]       mant;
    logic [W-1:0]         res_c;
    logic                 exc_c;

    // Unpack, classify, order by magnitude and align.
    always_comb begin
        a_sign = a_operand[W-1];
        a_exp  = a_operand[W-2:FRAC_BITS];
        a_frac = a_operand[FRAC_BITS-1:0];
        b_sign = b_operand[W-1] ^ AddBar_Sub;
        b_exp  = b_operand[W-2:FRAC_BITS];
        b_frac = b_operand[FRAC_BITS-1:0];

        a_nan  = (a_exp == EXP_MAX) && (a_frac != '0);
        b_nan  = (b_exp == EXP_MAX) && (b_frac != '0);
        a_inf  = (a_exp == EXP_MAX) && (a_frac == '0);
        b_inf  = (b_exp == EXP_MAX) && (b_frac == '0);
        a_zero = (a_exp == '0);
        b_zero = (b_exp == '0);

        swap   = {b_exp, b_frac} > {a_exp, a_frac};
        l_sign = swap ? b_sign : a_sign;
        l_exp  = swap ? b_exp  : a_exp;
        l_frac = swap ? b_frac : a_frac;
        s_sign = swap ? a_sign : b_sign;
        s_exp  = swap ? a_exp  : b_exp;
        s_frac = swap ? a_frac : b_frac;

        eff_sub  = l_sign ^ s_sign;
        exp_diff = l_exp - s_exp;
        ext_l    = {1'b1, l_frac, 3'b000};
        ext_s    = {1'b1, s_frac, 3'b000};

        if (exp_diff >= SHIFT_LIM) begin
            aligned = EXT_W'(1);
        end else begin
            aligned = (ext_s >> exp_diff)
                    | EXT_W'(|(ext_s & ((EXT_W'(1) << exp_diff) - EXT_W'(1))));
        end
    end

    // Add or subtract, normalize, round.
    always_comb begin
        sum      = {1'b0, ext_l} + {1'b0, aligned};
        dif      = ext_l - aligned;
        lz       = lzc(dif);
        mag_zero = eff_sub && (dif == '0);
        norm     = sum[EXT_W-1:0];
        exp_n    = {2'b00, l_exp};

        if (!eff_sub) begin
            if (sum[EXT_W]) begin
                norm  = sum[EXT_W:1] | EXT_W'(sum[0]);
                exp_n = {2'b00, l_exp} + XW'(1);
            end
        end else begin
            norm  = dif << lz;
            exp_n = {2'b00, l_exp} - XW'(lz);
        end

        round_up = 1'b0;
`ifdef ROUND_NEAREST_EN
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
`endif
        mant = (SIG_W+1)'({1'b0, norm} >> 3) + (SIG_W+1)'(round_up);

        if (mant[SIG_W]) begin
            exp_r  = exp_n + XW'(1);
            frac_r = mant[FRAC_BITS:1];
        end else begin
            exp_r  = exp_n;
            frac_r = mant[FRAC_BITS-1:0];
        end
    end

    // Result selection: specials, zeros, then the arithmetic path.
    always_comb begin
        res_c = '0;
        exc_c = 1'b0;
        if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign))) begin
            res_c = QNAN;
            exc_c = 1'b1;
        end else if (a_inf) begin
            res_c = {a_sign, EXP_MAX, FRAC_BITS'(0)};
            exc_c = 1'b1;
        end else if (b_inf) begin
            res_c = {b_sign, EXP_MAX, FRAC_BITS'(0)};
            exc_c = 1'b1;
        end else if (a_zero && b_zero) begin
            res_c = {a_sign & b_sign, (W-1)'(0)};
        end else if (a_zero) begin
            res_c = {b_sign, b_operand[W-2:0]};
        end else if (b_zero) begin
            res_c = a_operand;
        end else if (mag_zero || exp_r[XW-1] || (exp_r == '0)) begin
            res_c = '0;
        end else if (exp_r >= {2'b00, EXP_MAX}) begin
            res_c = {l_sign, EXP_MAX, FRAC_BITS'(0)};
            exc_c = 1'b1;
        end else begin
            res_c = {l_sign, exp_r[EXP_BITS-1:0], frac_r};
        end
    end

    // Output stage; result/Exception hold when no operation is issued.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            out_valid <= 1'b0;
            result    <= '0;
            Exception <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result    <= res_c;
                Exception <= exc_c;
            end
        end
    end

endmodule

// File: tb/tb_addition_subtraction.sv
// Directed-vector bench for addition_subtraction; expectations follow ROUND_NEAREST_EN if defined.
module tb_addition_subtraction;

    logic        CLK;
    logic        RESET_N;
    logic        in_valid;
    logic [31:0] a_operand;
    logic [31:0] b_operand;
    logic        AddBar_Sub;
    logic        out_valid;
    logic        Exception;
    logic [31:0] result;

    addition_subtraction dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .in_valid   (in_valid),
        .a_operand  (a_operand),
        .b_operand  (b_operand),
        .AddBar_Sub (AddBar_Sub),
        .out_valid  (out_valid),
        .Exception  (Exception),
        .result     (result)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] res;
        logic        exc;
    } vec_t;

`ifdef ROUND_NEAREST_EN
    localparam logic [31:0] R_STICKY = 32'h3F80_0001;
    localparam logic [31:0] R_CARRY  = 32'h4000_0000;
`else
    localparam logic [31:0] R_STICKY = 32'h3F80_0000;
    localparam logic [31:0] R_CARRY  = 32'h3FFF_FFFF;
`endif

    int   pass_cnt;
    int   check_cnt;
    vec_t vecs[$];

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic op,
                                input logic [31:0] res, input logic exc);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.res = res; v.exc = exc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        check_cnt++;
        if (act === exp_v) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp_v);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic op);
        a_operand  = a;
        b_operand  = b;
        AddBar_Sub = op;
        in_valid   = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] acc;
        logic [31:0] acc_exp [5];

        pass_cnt   = 0;
        check_cnt  = 0;
        RESET_N    = 1'b0;
        in_valid   = 1'b0;
        a_operand  = '0;
        b_operand  = '0;
        AddBar_Sub = 1'b0;

        vecs.push_back(mk(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 1'b0));
        vecs.push_back(mk(32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 1'b0));
        vecs.push_back(mk(32'h3F80_0000, 32'hBF80_0000, 1'b0, 32'h0000_0000, 1'b0));
        vecs.push_back(mk(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 1'b1));
        vecs.push_back(mk(32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7F80_0000, 1'b1));
        vecs.push_back(mk(32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 1'b1));
        vecs.push_back(mk(32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 1'b1));
        vecs.push_back(mk(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 1'b0));
        vecs.push_back(mk(32'h3F80_0000, 32'h3380_0001, 1'b0, R_STICKY,      1'b0));
        vecs.push_back(mk(32'h3FFF_FFFF, 32'h3380_0000, 1'b0, R_CARRY,       1'b0));
        vecs.push_back(mk(32'h3F80_0001, 32'h3F80_0000, 1'b1, 32'h3400_0000, 1'b0));
        vecs.push_back(mk(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0));
        vecs.push_back(mk(32'h0000_0001, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 1'b0));
        vecs.push_back(mk(32'h3F80_0000, 32'hBF80_0000, 1'b1, 32'h4000_0000, 1'b0));
        vecs.push_back(mk(32'h0000_0000, 32'h3F80_0000, 1'b1, 32'hBF80_0000, 1'b0));
        vecs.push_back(mk(32'hFF80_0000, 32'h3F80_0000, 1'b0, 32'hFF80_0000, 1'b1));
        vecs.push_back(mk(32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, 1'b1));
        vecs.push_back(mk(32'h7F7F_FFFF, 32'hFF7F_FFFF, 1'b1, 32'h7F80_0000, 1'b1));
        vecs.push_back(mk(32'hBF80_0000, 32'hC000_0000, 1'b0, 32'hC040_0000, 1'b0));
        vecs.push_back(mk(32'h3FC0_0000, 32'h4020_0000, 1'b1, 32'hBF80_0000, 1'b0));
        vecs.push_back(mk(32'h0080_0001, 32'h0080_0000, 1'b1, 32'h0000_0000, 1'b0));

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result",    result,         32'h0);
        check("reset Exception", 32'(Exception), 32'd0);

        // Table vectors issued back to back
        @(negedge CLK);
        RESET_N = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].op);
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d result", i),    result,         vecs[i].res);
            check($sformatf("vec%0d Exception", i), 32'(Exception), 32'(vecs[i].exc));
        end

        // Idle cycle holds last result/Exception
        in_valid = 1'b0;
        @(posedge CLK);
        #1;
        check("idle out_valid", 32'(out_valid), 32'd0);
        check("idle result",    result,         vecs[vecs.size()-1].res);
        check("idle Exception", 32'(Exception), 32'(vecs[vecs.size()-1].exc));

        // Reset asserted mid-stream with an operation in flight
        drive(32'h7F80_0000, 32'h3F80_0000, 1'b0);
        @(posedge CLK);
        #1;
        check("pre-reset Exception", 32'(Exception), 32'd1);
        drive(32'h3F80_0000, 32'h4000_0000, 1'b0);
        #2;
        RESET_N = 1'b0;
        #1;
        check("async reset out_valid", 32'(out_valid), 32'd0);
        check("async reset result",    result,         32'h0);
        check("async reset Exception", 32'(Exception), 32'd0);
        @(posedge CLK);
        #1;
        check("held reset out_valid", 32'(out_valid), 32'd0);
        check("held reset result",    result,         32'h0);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        check("post-reset out_valid", 32'(out_valid), 32'd1);
        check("post-reset result",    result,         32'h4040_0000);

        // Accumulate 0.5 five times, feeding each result back
        acc_exp[0] = 32'h3F00_0000;
        acc_exp[1] = 32'h3F80_0000;
        acc_exp[2] = 32'h3FC0_0000;
        acc_exp[3] = 32'h4000_0000;
        acc_exp[4] = 32'h4020_0000;
        acc = 32'h0;
        for (int i = 0; i < 5; i++) begin
            drive(acc, 32'h3F00_0000, 1'b0);
            @(posedge CLK);
            #1;
            check($sformatf("acc%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("acc%0d result", i),    result,         acc_exp[i]);
            acc = result;
        end
        in_valid = 1'b0;
        @(posedge CLK);
        #1;
        check("acc idle out_valid", 32'(out_valid), 32'd0);
        check("acc final result",   result,         32'h4020_0000);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
